// File: rtl/coffee_dispense_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// coffee_pkg
// Shared types and constants for the coffee dispense sequencer:
//   - state_e  : sequencer FSM states
//   - ingr_e   : ingredient stages, in fixed pour order
//   - recipe_e : recipe identifiers, in row order of the default time table
//   - DEFAULT_TIMES / default_time() : factory time table, in time units
// -----------------------------------------------------------------------------
package coffee_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_POUR,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    WATER,
    COFFEE,
    MILK,
    CHOCOLATE,
    SUGAR
  } ingr_e;

  typedef enum logic [1:0] {
    EXPRESSO,
    WITH_MILK,
    CAPPUCCINO,
    MOCACCINO
  } recipe_e;

  localparam int DEF_RECIPES = 4;
  localparam int DEF_INGR    = 5;
  localparam int DEF_TIME_W  = 4;

  typedef logic [DEF_TIME_W-1:0] def_time_t;

  // Rows indexed by recipe_e, columns by ingr_e.
  localparam def_time_t DEFAULT_TIMES [DEF_RECIPES][DEF_INGR] = '{
    '{4'd2, 4'd3, 4'd0, 4'd0, 4'd1},  // EXPRESSO
    '{4'd2, 4'd2, 4'd1, 4'd0, 4'd1},  // WITH_MILK
    '{4'd2, 4'd1, 4'd2, 4'd0, 4'd1},  // CAPPUCCINO
    '{4'd1, 4'd1, 4'd1, 4'd2, 4'd1}   // MOCACCINO
  };

  // Factory time for (recipe, ingredient); cells outside the factory table
  // (larger parameterisations) default to 0, i.e. the stage is skipped.
  function automatic int default_time(input int r, input int i);
    if (r >= 0 && r < DEF_RECIPES && i >= 0 && i < DEF_INGR)
      return int'(DEFAULT_TIMES[r[1:0]][i[2:0]]);
    else
      return 0;
  endfunction

endpackage

// File: rtl/coffee_dispense_sequencer_if.sv
// -----------------------------------------------------------------------------
// coffee_dispense_sequencer_if
// Order/valve bundle between the order-entry FSM and the sequencer.
//   master : order side   (drives start, recipe, abort; observes status/valves)
//   slave  : sequencer    (observes start, recipe, abort; drives status/valves)
// Signals:
//   start, recipe, abort          order request, recipe index, cancel
//   busy, valve, ingr_idx,        sequencer status and one-hot valve drive
//   units_left, done, err
// -----------------------------------------------------------------------------
interface coffee_dispense_sequencer_if #(
  parameter int N_INGR   = 5,
  parameter int TIME_W   = 4,
  parameter int RECIPE_W = 2
);
  localparam int IDX_W = $clog2(N_INGR + 1);

  logic                start;
  logic [RECIPE_W-1:0] recipe;
  logic                abort;
  logic                busy;
  logic [N_INGR-1:0]   valve;
  logic [IDX_W-1:0]    ingr_idx;
  logic [TIME_W-1:0]   units_left;
  logic                done;
  logic                err;

  modport master (
    output start, recipe, abort,
    input  busy, valve, ingr_idx, units_left, done, err
  );

  modport slave (
    input  start, recipe, abort,
    output busy, valve, ingr_idx, units_left, done, err
  );

endinterface

// File: rtl/coffee_dispense_sequencer_unit_timer.sv
// -----------------------------------------------------------------------------
// coffee_unit_timer
// Prescaler (0..TICK_DIV-1) feeding a unit down-counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load units_left with load_val and restart the prescaler
//   load_val     units for the new stage
//   run          advance the prescaler (valve open)
//   clear        force both counters to zero
//   units_left   units remaining, including the current one
//   last         terminal count of the final unit of the stage
// Priority: clear > load > run.
// -----------------------------------------------------------------------------
module coffee_unit_timer #(
  parameter int TIME_W   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              run,
  input  logic              clear,
  output logic [TIME_W-1:0] units_left,
  output logic              last
);

  // A one-cycle unit needs no prescaler state; keep one bit so the
  // declaration stays legal.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]  pre_q;
  logic [TIME_W-1:0] units_q;
  logic              tick;

  generate
    if (TICK_DIV > 1) begin : g_div
      assign tick = (pre_q == PRE_W'(TICK_DIV - 1));
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  assign units_left = units_q;
  assign last       = run && tick && (units_q == TIME_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      units_q <= '0;
    end else if (clear) begin
      pre_q   <= '0;
      units_q <= '0;
    end else if (load) begin
      pre_q   <= '0;
      units_q <= load_val;
    end else if (run) begin
      if (tick) begin
        pre_q   <= '0;
        units_q <= units_q - TIME_W'(1);
      end else begin
        pre_q   <= pre_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// coffee_dispense_sequencer
// Runs one drink order through the ingredient stages in fixed order, opening
// one valve at a time for time[recipe][stage] units of TICK_DIV cycles each.
// Zero-time stages are skipped at one SCAN cycle each; abort or an invalid
// recipe ends the order with done+err.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     start/recipe/abort in; busy/valve/ingr_idx/units_left/
//                   done/err out (all outputs registered)
//   cfg_we, cfg_recipe, cfg_ingr, cfg_time
//                   time-table write port, present only when
//                   COFFEE_SEQ_PROG_TABLE_EN is defined. Without the macro the
//                   table is the constant from coffee_pkg.
// -----------------------------------------------------------------------------
module coffee_dispense_sequencer
  import coffee_pkg::*;
#(
  parameter int N_RECIPES = 4,
  parameter int N_INGR    = 5,
  parameter int TIME_W    = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int RECIPE_W  = $clog2(N_RECIPES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef COFFEE_SEQ_PROG_TABLE_EN
  input  logic                      cfg_we,
  input  logic [RECIPE_W-1:0]       cfg_recipe,
  input  logic [$clog2(N_INGR)-1:0] cfg_ingr,
  input  logic [TIME_W-1:0]         cfg_time,
`endif
  coffee_dispense_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(N_INGR + 1);

  state_e              state_q;
  logic                busy_q;
  logic [N_INGR-1:0]   valve_q;
  logic [IDX_W-1:0]    ingr_idx_q;
  logic                done_q;
  logic                err_q;
  logic [RECIPE_W-1:0] recipe_q;

  logic [TIME_W-1:0]   tbl [N_RECIPES][N_INGR];
  logic [TIME_W-1:0]   cur_time;
  logic [TIME_W-1:0]   units_left;
  logic                stage_last;
  logic                scan_end;
  logic                recipe_ok;
  logic                in_order;
  logic                timer_load;
  logic                timer_run;
  logic                timer_clear;

  // ---------------------------------------------------------------------------
  // Time table
  // ---------------------------------------------------------------------------
`ifdef COFFEE_SEQ_PROG_TABLE_EN
  // NOTE: this register array is reset on purpose, so every power-up starts
  // from the factory recipes; it is small enough that reset flops are cheap
  // and it avoids pouring with garbage times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_RECIPES; r++)
        for (int i = 0; i < N_INGR; i++)
          tbl[r][i] <= TIME_W'(default_time(r, i));
    end else if (cfg_we && !busy_q &&
                 int'(cfg_recipe) < N_RECIPES && int'(cfg_ingr) < N_INGR) begin
      for (int r = 0; r < N_RECIPES; r++)
        for (int i = 0; i < N_INGR; i++)
          if (int'(cfg_recipe) == r && int'(cfg_ingr) == i)
            tbl[r][i] <= cfg_time;
    end
  end
`else
  for (genvar r = 0; r < N_RECIPES; r++) begin : g_rec
    for (genvar i = 0; i < N_INGR; i++) begin : g_ingr
      assign tbl[r][i] = TIME_W'(default_time(r, i));
    end
  end
`endif

  // Lookup for the current stage; the final index (N_INGR) reads as 0.
  always_comb begin
    // NOTE: default first so no path leaves cur_time unassigned (no latch).
    cur_time = '0;
    for (int r = 0; r < N_RECIPES; r++)
      for (int i = 0; i < N_INGR; i++)
        if (int'(recipe_q) == r && int'(ingr_idx_q) == i)
          cur_time = tbl[r][i];
  end

  // ---------------------------------------------------------------------------
  // Unit timer control
  // ---------------------------------------------------------------------------
  assign scan_end    = (ingr_idx_q == IDX_W'(N_INGR));
  assign recipe_ok   = (int'(bus.recipe) < N_RECIPES);
  assign in_order    = (state_q == ST_SCAN) || (state_q == ST_POUR);
  assign timer_load  = (state_q == ST_SCAN) && !bus.abort && !scan_end && (cur_time != '0);
  assign timer_run   = (state_q == ST_POUR) && !bus.abort;
  assign timer_clear = bus.abort && in_order;

  coffee_unit_timer #(
    .TIME_W   (TIME_W),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_val   (cur_time),
    .run        (timer_run),
    .clear      (timer_clear),
    .units_left (units_left),
    .last       (stage_last)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM; every output is a flop so the valve drivers see clean edges.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      valve_q    <= '0;
      ingr_idx_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      recipe_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout; this default is overridden by the
      // later assignments below, giving a single-cycle done pulse.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            recipe_q   <= bus.recipe;
            ingr_idx_q <= '0;
            busy_q     <= 1'b1;
            if (recipe_ok) begin
              err_q   <= 1'b0;
              state_q <= ST_SCAN;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_SCAN: begin
          if (bus.abort) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (scan_end) begin
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (cur_time == '0) begin
            ingr_idx_q <= ingr_idx_q + IDX_W'(1);
          end else begin
            valve_q <= N_INGR'(1) << ingr_idx_q;
            state_q <= ST_POUR;
          end
        end

        ST_POUR: begin
          // Abort wins even on the terminal-count cycle.
          if (bus.abort) begin
            valve_q <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (stage_last) begin
            valve_q    <= '0;
            ingr_idx_q <= ingr_idx_q + IDX_W'(1);
            state_q    <= ST_SCAN;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          valve_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valve      = valve_q;
  assign bus.ingr_idx   = ingr_idx_q;
  assign bus.units_left = units_left;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_coffee_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coffee_dispense_sequencer
// Two sequencers share clk/rst_n:
//   dut_a : TICK_DIV=4, recipe width 3 (indices 4..7 are invalid recipes)
//   dut_b : TICK_DIV=1, default recipe width
// Expected per-cycle behaviour of an order is built from the recipe table as
// a list of stages: one SCAN cycle per stage, T*TICK_DIV open-valve cycles per
// non-zero stage, a closing SCAN cycle, then a DONE cycle. An abort replaces
// the remainder of that list with a single DONE+err cycle.
// With COFFEE_SEQ_PROG_TABLE_EN defined, table writes on dut_a are exercised.
// -----------------------------------------------------------------------------
module tb_coffee_dispense_sequencer;

  typedef struct packed {
    logic [4:0] valve;
    logic [2:0] idx;
    logic [3:0] units;
    logic       done;
    logic       err;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tm [4][5];
  exp_t trace [$];

  coffee_dispense_sequencer_if #(.N_INGR(5), .TIME_W(4), .RECIPE_W(3)) bus_a ();
  coffee_dispense_sequencer_if #(.N_INGR(5), .TIME_W(4), .RECIPE_W(2)) bus_b ();

`ifdef COFFEE_SEQ_PROG_TABLE_EN
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_recipe = '0;
  logic [2:0] cfg_ingr = '0;
  logic [3:0] cfg_time = '0;
`endif

  coffee_dispense_sequencer #(
    .N_RECIPES(4), .N_INGR(5), .TIME_W(4), .TICK_DIV(4), .RECIPE_W(3)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef COFFEE_SEQ_PROG_TABLE_EN
    .cfg_we     (cfg_we),
    .cfg_recipe (cfg_recipe),
    .cfg_ingr   (cfg_ingr),
    .cfg_time   (cfg_time),
`endif
    .bus        (bus_a)
  );

  coffee_dispense_sequencer #(
    .N_RECIPES(4), .N_INGR(5), .TIME_W(4), .TICK_DIV(1), .RECIPE_W(2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef COFFEE_SEQ_PROG_TABLE_EN
    .cfg_we     (1'b0),
    .cfg_recipe (2'd0),
    .cfg_ingr   (3'd0),
    .cfg_time   (4'd0),
`endif
    .bus        (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] v, input int idx, input int u,
                              input logic d, input logic e, input logic b);
    exp_t x;
    x.valve = v;
    x.idx   = 3'(idx);
    x.units = 4'(u);
    x.done  = d;
    x.err   = e;
    x.busy  = b;
    return x;
  endfunction

  function automatic exp_t sample(input int sel);
    if (sel == 0)
      return mk(bus_a.valve, int'(bus_a.ingr_idx), int'(bus_a.units_left),
                bus_a.done, bus_a.err, bus_a.busy);
    else
      return mk(bus_b.valve, int'(bus_b.ingr_idx), int'(bus_b.units_left),
                bus_b.done, bus_b.err, bus_b.busy);
  endfunction

  task automatic drive(input int sel, input logic st, input int rec, input logic ab);
    bus_a.start  = (sel == 0) ? st : 1'b0;
    bus_a.abort  = (sel == 0) ? ab : 1'b0;
    bus_a.recipe = 3'(rec);
    bus_b.start  = (sel == 1) ? st : 1'b0;
    bus_b.abort  = (sel == 1) ? ab : 1'b0;
    bus_b.recipe = 2'(rec);
  endtask

  // Expected cycle-by-cycle view of one order, starting the cycle after start.
  task automatic build_trace(input int rec, input int tick);
    trace.delete();
    if (rec >= 4) begin
      trace.push_back(mk(5'd0, 0, 0, 1'b1, 1'b1, 1'b1));
      return;
    end
    for (int i = 0; i < 5; i++) begin
      int t;
      t = tm[rec][i];
      trace.push_back(mk(5'd0, i, 0, 1'b0, 1'b0, 1'b1));
      for (int p = 0; p < t * tick; p++)
        trace.push_back(mk(5'(1 << i), i, t - p / tick, 1'b0, 1'b0, 1'b1));
    end
    trace.push_back(mk(5'd0, 5, 0, 1'b0, 1'b0, 1'b1));
    trace.push_back(mk(5'd0, 5, 0, 1'b1, 1'b0, 1'b1));
  endtask

  // abort_at: -1 none, -2 random cycle, else the trace cycle carrying abort.
  // cfg_at  : trace cycle on which a (must-be-ignored) table write is issued.
  task automatic run_order(input string name, input int sel, input int rec,
                           input int abort_at, input int cfg_at, input bit noise);
    int ab_cyc;
    exp_t got, e;
    build_trace(rec, (sel == 0) ? 4 : 1);
    ab_cyc = abort_at;
    if (ab_cyc == -2) ab_cyc = $urandom_range(0, trace.size() - 1);
    if (ab_cyc >= 0 && ab_cyc < trace.size() - 1) begin
      exp_t keep;
      keep = trace[ab_cyc];
      while (trace.size() > ab_cyc + 1) void'(trace.pop_back());
      trace.push_back(mk(5'd0, int'(keep.idx), 0, 1'b1, 1'b1, 1'b1));
    end
    // Start (possibly together with abort, which IDLE must ignore).
    drive(sel, 1'b1, rec, noise ? 1'($urandom_range(0, 1)) : 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b0, rec, 1'b0);
    for (int j = 0; j < trace.size(); j++) begin
      got = sample(sel);
      e   = trace[j];
      check($sformatf("%s valve c%0d", name, j), 32'(got.valve), 32'(e.valve));
      check($sformatf("%s busy c%0d",  name, j), 32'(got.busy),  32'(e.busy));
      check($sformatf("%s idx c%0d",   name, j), 32'(got.idx),   32'(e.idx));
      check($sformatf("%s units c%0d", name, j), 32'(got.units), 32'(e.units));
      check($sformatf("%s done c%0d",  name, j), 32'(got.done),  32'(e.done));
      if (e.done) check($sformatf("%s err c%0d", name, j), 32'(got.err), 32'(e.err));
      // Start is ignored outside IDLE; abort is ignored in DONE.
      drive(sel, noise ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 7),
            (j == ab_cyc) || (noise && j == trace.size() - 1 && $urandom_range(0, 1) == 1));
`ifdef COFFEE_SEQ_PROG_TABLE_EN
      if (j == cfg_at) begin
        cfg_we = 1'b1; cfg_recipe = 3'd0; cfg_ingr = 3'd1; cfg_time = 4'd7;
      end
`endif
      @(posedge clk); #1;
      drive(sel, 1'b0, rec, 1'b0);
`ifdef COFFEE_SEQ_PROG_TABLE_EN
      cfg_we = 1'b0;
`endif
    end
    got = sample(sel);
    check({name, " idle busy"},  32'(got.busy),  32'd0);
    check({name, " idle valve"}, 32'(got.valve), 32'd0);
    check({name, " idle done"},  32'(got.done),  32'd0);
  endtask

`ifdef COFFEE_SEQ_PROG_TABLE_EN
  task automatic cfg_write(input int r, input int i, input int t);
    cfg_we = 1'b1; cfg_recipe = 3'(r); cfg_ingr = 3'(i); cfg_time = 4'(t);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask
`endif

  initial begin
    exp_t got;
    tm = '{'{2, 3, 0, 0, 1}, '{2, 2, 1, 0, 1}, '{2, 1, 2, 0, 1}, '{1, 1, 1, 2, 1}};
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 1'b0);
    #23;
    check("reset a", 32'(sample(0)), 32'd0);
    check("reset b", 32'(sample(1)), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recipe 0 at TICK_DIV=4: water 8 cycles, coffee 12, two skips, sugar 4.
    run_order("t1 rec0", 0, 0, -1, -1, 1'b0);
    // Recipe 3 at TICK_DIV=1: 1,1,1,2,1 cycle pours each after one SCAN cycle.
    run_order("t2 rec3", 1, 3, -1, -1, 1'b0);
    // Abort in the middle of the coffee pour of recipe 1, then a clean order.
    run_order("t3 abort", 0, 1, 12, -1, 1'b0);
    run_order("t3 after", 0, 1, -1, -1, 1'b0);
    // Abort on the terminal-count cycle of the water stage (last open cycle).
    run_order("t3 abort tc", 0, 1, 8, -1, 1'b0);
    // Invalid recipe: no valve, done+err right after acceptance.
    run_order("t4 rec5", 0, 5, -1, -1, 1'b0);

    // Reset mid-pour: outputs drop before the next clock edge.
    drive(0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    got = sample(0);
    check("t5 pouring valve", 32'(got.valve), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    got = sample(0);
    check("t5 async valve", 32'(got.valve), 32'd0);
    check("t5 async busy",  32'(got.busy),  32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_order("t5 restart", 0, 2, -1, -1, 1'b0);

    // Randomised orders with random aborts and input noise.
    for (int k = 0; k < 24; k++) begin
      int sel, rec, ab;
      sel = $urandom_range(0, 3) == 0 ? 1 : 0;
      rec = $urandom_range(0, 3);
      if (sel == 0 && $urandom_range(0, 4) == 0) rec = 4 + $urandom_range(0, 3);
      ab  = ($urandom_range(0, 1) == 1) ? -2 : -1;
      run_order($sformatf("rnd%0d", k), sel, rec, ab, -1, 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

`ifdef COFFEE_SEQ_PROG_TABLE_EN
    // Idle write: recipe 0 water becomes 0 and is skipped next order.
    cfg_write(0, 0, 0);
    tm[0][0] = 0;
    run_order("t6 skip water", 0, 0, -1, -1, 1'b0);
    // Out-of-range writes are dropped.
    cfg_write(0, 5, 9);
    cfg_write(4, 0, 9);
    run_order("t6 oor", 0, 0, -1, -1, 1'b0);
    // Write while busy is dropped; this and the next order keep coffee=3.
    run_order("t6 busy wr", 0, 0, -1, 3, 1'b0);
    run_order("t6 after", 0, 0, -1, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
